// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: two-requester arbiter and sequencer for the register bus.
// One access per grant, fixed four-state sequence, optional owner lock.

module reg_bus_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req0,
   input  logic              i_req1,
   input  logic              i_we0,
   input  logic              i_we1,
   input  logic [ADDR_W-1:0] i_addr0,
   input  logic [ADDR_W-1:0] i_addr1,
   input  logic [DATA_W-1:0] i_wdata0,
   input  logic [DATA_W-1:0] i_wdata1,
   input  logic              i_lock0,
   input  logic              i_lock1,
   output logic              o_ack0,
   output logic              o_ack1,
   output logic [DATA_W-1:0] o_rsp_rdata,
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_reg_addr,
   output logic [DATA_W-1:0] o_reg_wdata,
   output logic              o_reg_write,
   output logic              o_reg_read,
   input  logic [DATA_W-1:0] i_reg_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_ACK
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic              r_cur;
   logic              r_rd;
   logic              r_last_grant;
   logic              r_owner_locked;
   logic              r_ack0;
   logic              r_ack1;
   logic              r_busy;
   logic              r_reg_write;
   logic              r_reg_read;
   logic [ADDR_W-1:0] r_reg_addr;
   logic [DATA_W-1:0] r_reg_wdata;
   logic [DATA_W-1:0] r_rsp_rdata;

   logic              w_any_req;
   logic              w_owner_req;
   logic              w_lock_hit;
   logic              w_win;
   logic              w_win_we;
   logic [ADDR_W-1:0] w_win_addr;
   logic [DATA_W-1:0] w_win_wdata;
   logic              w_cur_lock;

   logic              w_cur_nxt;
   logic              w_rd_nxt;
   logic              w_last_grant_nxt;
   logic              w_owner_locked_nxt;
   logic              w_ack0_nxt;
   logic              w_ack1_nxt;
   logic              w_reg_write_nxt;
   logic              w_reg_read_nxt;
   logic [ADDR_W-1:0] w_reg_addr_nxt;
   logic [DATA_W-1:0] w_reg_wdata_nxt;
   logic [DATA_W-1:0] w_rsp_rdata_nxt;

   // The owner is whoever completed last; it only matters while locked.
   assign w_any_req   = i_req0 | i_req1;
   assign w_owner_req = r_last_grant ? i_req1 : i_req0;
   assign w_lock_hit  = r_owner_locked & w_owner_req;
   assign w_cur_lock  = r_cur ? i_lock1 : i_lock0;

   // Winner: locked owner first, else round-robin against last grant.
   always_comb begin
      w_win = 1'b0;
      if (w_lock_hit) begin
         w_win = r_last_grant;
      end else if (i_req0 && i_req1) begin
         w_win = ~r_last_grant;
      end else begin
         w_win = ~i_req0;
      end
   end

   // Qualifiers of the selected requester.
   always_comb begin
      w_win_we    = w_win ? i_we1 : i_we0;
      w_win_addr  = w_win ? i_addr1 : i_addr0;
      w_win_wdata = w_win ? i_wdata1 : i_wdata0;
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: fixed IDLE/ISSUE/CAPTURE/ACK walk per access.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:    w_state_nxt = w_any_req ? S_ISSUE : S_IDLE;
         S_ISSUE:   w_state_nxt = S_CAPTURE;
         S_CAPTURE: w_state_nxt = S_ACK;
         S_ACK:     w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // Output logic: next values for every registered output and flag.
   always_comb begin
      w_cur_nxt          = r_cur;
      w_rd_nxt           = r_rd;
      w_last_grant_nxt   = r_last_grant;
      w_owner_locked_nxt = r_owner_locked;
      w_ack0_nxt         = 1'b0;
      w_ack1_nxt         = 1'b0;
      w_reg_write_nxt    = 1'b0;
      w_reg_read_nxt     = 1'b0;
      w_reg_addr_nxt     = r_reg_addr;
      w_reg_wdata_nxt    = r_reg_wdata;
      w_rsp_rdata_nxt    = r_rsp_rdata;
      unique case (r_state)
         S_IDLE: begin
            if (r_owner_locked && !w_owner_req) begin
               w_owner_locked_nxt = 1'b0;
            end
            if (w_any_req) begin
               w_cur_nxt       = w_win;
               w_rd_nxt        = ~w_win_we;
               w_reg_addr_nxt  = w_win_addr;
               w_reg_wdata_nxt = w_win_wdata;
               w_reg_write_nxt = w_win_we;
               w_reg_read_nxt  = ~w_win_we;
            end
         end
         S_ISSUE: begin
            w_reg_write_nxt = 1'b0;
            w_reg_read_nxt  = 1'b0;
         end
         S_CAPTURE: begin
            if (r_rd) begin
               w_rsp_rdata_nxt = i_reg_rdata;
            end
            w_ack0_nxt         = ~r_cur;
            w_ack1_nxt         = r_cur;
            w_last_grant_nxt   = r_cur;
            w_owner_locked_nxt = w_cur_lock;
         end
         S_ACK: begin
            w_ack0_nxt = 1'b0;
            w_ack1_nxt = 1'b0;
         end
         default: begin
            w_ack0_nxt = 1'b0;
            w_ack1_nxt = 1'b0;
         end
      endcase
   end

   // Output and bookkeeping registers; reset abandons any access.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cur          <= 1'b0;
         r_rd           <= 1'b0;
         r_last_grant   <= 1'b1;
         r_owner_locked <= 1'b0;
         r_ack0         <= 1'b0;
         r_ack1         <= 1'b0;
         r_busy         <= 1'b0;
         r_reg_write    <= 1'b0;
         r_reg_read     <= 1'b0;
         r_reg_addr     <= '0;
         r_reg_wdata    <= '0;
         r_rsp_rdata    <= '0;
      end else begin
         r_cur          <= w_cur_nxt;
         r_rd           <= w_rd_nxt;
         r_last_grant   <= w_last_grant_nxt;
         r_owner_locked <= w_owner_locked_nxt;
         r_ack0         <= w_ack0_nxt;
         r_ack1         <= w_ack1_nxt;
         r_busy         <= (w_state_nxt != S_IDLE);
         r_reg_write    <= w_reg_write_nxt;
         r_reg_read     <= w_reg_read_nxt;
         r_reg_addr     <= w_reg_addr_nxt;
         r_reg_wdata    <= w_reg_wdata_nxt;
         r_rsp_rdata    <= w_rsp_rdata_nxt;
      end
   end

   assign o_ack0      = r_ack0;
   assign o_ack1      = r_ack1;
   assign o_busy      = r_busy;
   assign o_reg_write = r_reg_write;
   assign o_reg_read  = r_reg_read;
   assign o_reg_addr  = r_reg_addr;
   assign o_reg_wdata = r_reg_wdata;
   assign o_rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: scoreboard bench for reg_bus_arbiter.
// Expected accesses queued at drive time, matched against bus and ack events.

module tb_reg_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic        we0 = 1'b0, we1 = 1'b0;
   logic        lock0 = 1'b0, lock1 = 1'b0;
   logic [7:0]  addr0 = '0, addr1 = '0;
   logic [31:0] wdata0 = '0, wdata1 = '0;
   logic        ack0, ack1, busy, reg_write, reg_read;
   logic [31:0] rsp_rdata, reg_wdata, reg_rdata;
   logic [7:0]  reg_addr;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int          cyc;
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
   } strobe_t;

   typedef struct {
      int          cyc;
      logic [1:0]  ack;
      logic [31:0] rdata;
   } ack_t;

   typedef struct {
      bit          id;
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rsp;
   } exp_t;

   strobe_t     st_q[$];
   ack_t        ak_q[$];
   exp_t        exp_q[$];
   logic [31:0] rf[256];
   logic [31:0] sh[256];
   logic [31:0] last_rd = '0;
   bit          rf_ok = 1'b0;

   reg_bus_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req0(req0), .i_req1(req1),
      .i_we0(we0), .i_we1(we1),
      .i_addr0(addr0), .i_addr1(addr1),
      .i_wdata0(wdata0), .i_wdata1(wdata1),
      .i_lock0(lock0), .i_lock1(lock1),
      .o_ack0(ack0), .o_ack1(ack1),
      .o_rsp_rdata(rsp_rdata), .o_busy(busy),
      .o_reg_addr(reg_addr), .o_reg_wdata(reg_wdata),
      .o_reg_write(reg_write), .o_reg_read(reg_read),
      .i_reg_rdata(reg_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_val(input int i);
      return (i == 'hFE) ? 32'h5631_3030 : (32'hA500_0000 | i);
   endfunction

   // Register file: writes land at the strobe edge, reads return one cycle later.
   always @(posedge clk) begin
      if (!rf_ok) begin
         for (int i = 0; i < 256; i++) rf[i] <= init_val(i);
         rf_ok <= 1'b1;
      end else begin
         if (reg_write) rf[reg_addr] <= reg_wdata;
         if (reg_read) reg_rdata <= rf[reg_addr];
      end
   end

   // Bus and ack observer, sampled away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (reg_write || reg_read)
            st_q.push_back('{cyc, reg_write, reg_addr, reg_wdata});
         if (ack0 || ack1)
            ak_q.push_back('{cyc, {ack1, ack0}, rsp_rdata});
      end
   end

   task automatic push_exp(input bit id, input bit wr,
                           input logic [7:0] a, input logic [31:0] d);
      exp_t e;
      e.id = id;
      e.wr = wr;
      e.addr = a;
      e.wdata = d;
      if (wr) sh[a] = d;
      else last_rd = sh[a];
      e.rsp = last_rd;
      exp_q.push_back(e);
   endtask

   task automatic clear_q();
      st_q.delete();
      ak_q.delete();
      exp_q.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_acks(input int n, input int maxc, output bit ok);
      int k = 0;
      while (ak_q.size() < n && k < maxc) begin
         @(negedge clk);
         #1;
         k++;
      end
      ok = (ak_q.size() >= n);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle(3);
      checks++;
      if ({reg_write, reg_read, ack0, ack1, busy} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctl: wr/rd/ack0/ack1/busy=%b want 00000",
                  {reg_write, reg_read, ack0, ack1, busy});
      end
      checks++;
      if (reg_addr !== 8'h0 || reg_wdata !== 32'h0 || rsp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: addr=%h wdata=%h rsp=%h want all 0",
                  reg_addr, reg_wdata, rsp_rdata);
      end
   endtask

   task automatic test_contention();
      int c0, prev;
      bit ok;
      exp_t e;
      strobe_t s;
      ack_t a;
      clear_q();
      last_rd = '0;
      rst_n = 1'b1;
      c0 = cyc;
      req0 = 1; we0 = 0; addr0 = 8'h01;
      req1 = 1; we1 = 0; addr1 = 8'h02;
      push_exp(0, 0, 8'h01, 0);
      push_exp(1, 0, 8'h02, 0);
      push_exp(0, 0, 8'h01, 0);
      push_exp(1, 0, 8'h02, 0);
      wait_acks(4, 40, ok);
      req0 = 0; req1 = 0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL contention_timeout: acks=%0d want 4", ak_q.size());
      end
      prev = c0 - 1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (st_q.size() == 0 || ak_q.size() == 0) begin
            errors++;
            $display("FAIL contention: access to %h missing", e.addr);
         end else begin
            s = st_q.pop_front();
            a = ak_q.pop_front();
            if (s.wr !== e.wr || s.addr !== e.addr || a.ack !== {e.id, ~e.id}
                || a.rdata !== e.rsp || a.cyc - s.cyc != 2
                || a.cyc - prev != 4) begin
               errors++;
               $display("FAIL contention: wr=%b addr=%h ack=%b rd=%h lat=%0d gap=%0d want wr=%b addr=%h ack=%b rd=%h lat=2 gap=4",
                        s.wr, s.addr, a.ack, a.rdata, a.cyc - s.cyc, a.cyc - prev,
                        e.wr, e.addr, {e.id, ~e.id}, e.rsp);
            end
            prev = a.cyc;
         end
      end
   endtask

   task automatic test_single_write();
      int c0;
      bit ok;
      exp_t e;
      strobe_t s;
      ack_t a;
      idle(3);
      clear_q();
      c0 = cyc;
      req0 = 1; we0 = 1; addr0 = 8'h02; wdata0 = 32'h5;
      push_exp(0, 1, 8'h02, 32'h5);
      wait_acks(1, 10, ok);
      req0 = 0;
      idle(6);
      e = exp_q.pop_front();
      checks++;
      if (!ok || st_q.size() != 1 || ak_q.size() != 1) begin
         errors++;
         $display("FAIL write_count: strobes=%0d acks=%0d want 1 1",
                  st_q.size(), ak_q.size());
      end else begin
         s = st_q.pop_front();
         a = ak_q.pop_front();
         checks++;
         if (s.wr !== 1'b1 || s.addr !== e.addr || s.wdata !== e.wdata) begin
            errors++;
            $display("FAIL write_bus: wr=%b addr=%h wdata=%h want 1 %h %h",
                     s.wr, s.addr, s.wdata, e.addr, e.wdata);
         end
         checks++;
         if (a.ack !== 2'b01 || a.cyc != c0 + 3) begin
            errors++;
            $display("FAIL write_ack: ack=%b cyc=%0d want 01 cyc=%0d",
                     a.ack, a.cyc, c0 + 3);
         end
      end
   endtask

   task automatic test_single_read();
      bit ok;
      exp_t e;
      strobe_t s;
      ack_t a;
      idle(2);
      clear_q();
      req1 = 1; we1 = 0; addr1 = 8'hFE;
      push_exp(1, 0, 8'hFE, 0);
      wait_acks(1, 10, ok);
      req1 = 0;
      idle(2);
      req0 = 1; we0 = 1; addr0 = 8'h30; wdata0 = 32'h77;
      push_exp(0, 1, 8'h30, 32'h77);
      wait_acks(2, 10, ok);
      req0 = 0;
      idle(4);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL read_timeout: acks=%0d want 2", ak_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (st_q.size() == 0 || ak_q.size() == 0) begin
            errors++;
            $display("FAIL read_seq: access to %h missing", e.addr);
         end else begin
            s = st_q.pop_front();
            a = ak_q.pop_front();
            if (s.wr !== e.wr || s.addr !== e.addr || (e.wr && s.wdata !== e.wdata)
                || a.ack !== {e.id, ~e.id} || a.rdata !== e.rsp
                || a.cyc - s.cyc != 2) begin
               errors++;
               $display("FAIL read_seq: wr=%b addr=%h ack=%b rsp=%h lat=%0d want wr=%b addr=%h ack=%b rsp=%h lat=2",
                        s.wr, s.addr, a.ack, a.rdata, a.cyc - s.cyc,
                        e.wr, e.addr, {e.id, ~e.id}, e.rsp);
            end
         end
      end
      checks++;
      if (rsp_rdata !== 32'h5631_3030) begin
         errors++;
         $display("FAIL read_hold: rsp=%h want 56313030", rsp_rdata);
      end
   endtask

   task automatic test_lock();
      bit ok;
      exp_t e;
      strobe_t s;
      ack_t a;
      idle(2);
      clear_q();
      req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 32'hE8; lock0 = 1;
      push_exp(0, 1, 8'h10, 32'hE8);
      push_exp(0, 1, 8'h11, 32'h03);
      push_exp(1, 0, 8'h11, 0);
      idle(1);
      req1 = 1; we1 = 0; addr1 = 8'h11;
      wait_acks(1, 10, ok);
      addr0 = 8'h11; wdata0 = 32'h03; lock0 = 0;
      wait_acks(2, 10, ok);
      req0 = 0;
      wait_acks(3, 10, ok);
      req1 = 0;
      idle(4);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL lock_timeout: acks=%0d want 3", ak_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (st_q.size() == 0 || ak_q.size() == 0) begin
            errors++;
            $display("FAIL lock_seq: access to %h missing", e.addr);
         end else begin
            s = st_q.pop_front();
            a = ak_q.pop_front();
            if (s.wr !== e.wr || s.addr !== e.addr || (e.wr && s.wdata !== e.wdata)
                || a.ack !== {e.id, ~e.id} || a.rdata !== e.rsp
                || a.cyc - s.cyc != 2) begin
               errors++;
               $display("FAIL lock_seq: wr=%b addr=%h wd=%h ack=%b rsp=%h want wr=%b addr=%h wd=%h ack=%b rsp=%h",
                        s.wr, s.addr, s.wdata, a.ack, a.rdata,
                        e.wr, e.addr, e.wdata, {e.id, ~e.id}, e.rsp);
            end
         end
      end
   endtask

   task automatic test_early_drop();
      bit ok;
      exp_t e;
      strobe_t s;
      ack_t a;
      idle(2);
      clear_q();
      req0 = 1; we0 = 0; addr0 = 8'h05;
      push_exp(0, 0, 8'h05, 0);
      idle(1);
      req0 = 0;
      wait_acks(1, 10, ok);
      idle(8);
      e = exp_q.pop_front();
      checks++;
      if (!ok || st_q.size() != 1 || ak_q.size() != 1) begin
         errors++;
         $display("FAIL drop_count: strobes=%0d acks=%0d want 1 1",
                  st_q.size(), ak_q.size());
      end else begin
         s = st_q.pop_front();
         a = ak_q.pop_front();
         checks++;
         if (s.wr !== 1'b0 || s.addr !== e.addr || a.ack !== 2'b01
             || a.rdata !== e.rsp) begin
            errors++;
            $display("FAIL drop_acc: wr=%b addr=%h ack=%b rsp=%h want 0 %h 01 %h",
                     s.wr, s.addr, a.ack, a.rdata, e.addr, e.rsp);
         end
      end
   endtask

   task automatic test_reset_mid();
      int k, c0;
      bit ok;
      exp_t e;
      strobe_t s;
      ack_t a;
      idle(2);
      clear_q();
      req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 32'hAA;
      k = 0;
      while (st_q.size() == 0 && k < 10) begin
         idle(1);
         k++;
      end
      checks++;
      if (st_q.size() == 0) begin
         errors++;
         $display("FAIL rstmid_issue: strobe not seen");
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({reg_write, reg_read, busy, ack0, ack1} !== 5'b0 || reg_addr !== 8'h0) begin
         errors++;
         $display("FAIL rstmid_async: wr/rd/busy/ack0/ack1=%b addr=%h want 00000 00",
                  {reg_write, reg_read, busy, ack0, ack1}, reg_addr);
      end
      req1 = 1; we1 = 0; addr1 = 8'h20;
      idle(2);
      clear_q();
      last_rd = '0;
      rst_n = 1'b1;
      c0 = cyc;
      push_exp(0, 1, 8'h20, 32'hAA);
      push_exp(1, 0, 8'h20, 0);
      wait_acks(1, 10, ok);
      req0 = 0;
      wait_acks(2, 10, ok);
      req1 = 0;
      idle(4);
      checks++;
      if (!ok || ak_q.size() != 2 || ak_q[0].cyc != c0 + 3) begin
         errors++;
         $display("FAIL rstmid_first: acks=%0d first_cyc=%0d want 2 cyc=%0d",
                  ak_q.size(), (ak_q.size() > 0) ? ak_q[0].cyc : -1, c0 + 3);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (st_q.size() == 0 || ak_q.size() == 0) begin
            errors++;
            $display("FAIL rstmid_seq: access to %h missing", e.addr);
         end else begin
            s = st_q.pop_front();
            a = ak_q.pop_front();
            if (s.wr !== e.wr || s.addr !== e.addr || (e.wr && s.wdata !== e.wdata)
                || a.ack !== {e.id, ~e.id} || a.rdata !== e.rsp) begin
               errors++;
               $display("FAIL rstmid_seq: wr=%b addr=%h ack=%b rsp=%h want wr=%b addr=%h ack=%b rsp=%h",
                        s.wr, s.addr, a.ack, a.rdata,
                        e.wr, e.addr, {e.id, ~e.id}, e.rsp);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) sh[i] = init_val(i);
      test_reset();
      test_contention();
      test_single_write();
      test_single_read();
      test_lock();
      test_early_drop();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
